// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Holds the loader state encoding and the word/byte geometry used by the packer.
package loader_pkg;

    typedef enum logic [2:0] {
        ST_CLEAR = 3'd0,
        ST_RECV  = 3'd1,
        ST_WRITE = 3'd2,
        ST_RUN   = 3'd3,
        ST_HALT  = 3'd4,
        ST_ERR   = 3'd5
    } state_t;

    localparam int WORD_BYTES = 4;
    localparam int WORD_W     = WORD_BYTES * 8;
    localparam int BYTE_CNT_W = $clog2(WORD_BYTES);

    // The CPU is only let out of reset once a complete program is in memory.
    function automatic logic cpu_released(input state_t s);
        return (s == ST_RUN) || (s == ST_HALT);
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// The host (master) drives the stream; the loader (slave) drives the memory port.
interface imem_loader_if #(
    parameter int ADDR_W = 8
);
    logic              s_valid_i;
    logic [7:0]        s_data_i;
    logic              s_last_i;
    logic              s_ready_o;
    logic              imem_we_o;
    logic [ADDR_W-1:0] imem_addr_o;
    logic [31:0]       imem_wdata_o;

    modport master (
        output s_valid_i, s_data_i, s_last_i,
        input  s_ready_o, imem_we_o, imem_addr_o, imem_wdata_o
    );

    modport slave (
        input  s_valid_i, s_data_i, s_last_i,
        output s_ready_o, imem_we_o, imem_addr_o, imem_wdata_o
    );
endinterface

// File: rtl/imem_loader_byte_packer.sv
// Packs accepted bytes big-endian into 32-bit words: first byte ends up in [31:24].
// A 2-bit counter tracks position; o_word_valid pulses the cycle after the 4th byte.
module byte_packer
    import loader_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              i_clr,
    input  logic              i_push,
    input  logic [7:0]        i_data,
    output logic [WORD_W-1:0] o_word,
    output logic              o_word_valid,
    output logic              o_partial,
    output logic              o_fourth
);

    logic [BYTE_CNT_W-1:0] r_cnt;
    logic [WORD_W-1:0]     r_shift;
    logic                  r_word_valid;
    logic [WORD_W-1:0]     w_shift_next;
    logic                  w_fourth;

    // Each lane takes the byte of the lane below it; lane 0 takes the new byte.
    for (genvar gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
        if (gi == 0) begin : g_head
            assign w_shift_next[7:0] = i_data;
        end else begin : g_tail
            assign w_shift_next[8*gi +: 8] = r_shift[8*(gi-1) +: 8];
        end
    end

    assign w_fourth = (r_cnt == BYTE_CNT_W'(WORD_BYTES - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i || i_clr) begin
            r_cnt        <= '0;
            r_shift      <= '0;
            r_word_valid <= 1'b0;
        end else begin
            r_word_valid <= i_push && w_fourth;
            if (i_push) begin
                r_cnt   <= r_cnt + 1'b1;
                r_shift <= w_shift_next;
            end
        end
    end

    assign o_word       = r_shift;
    assign o_word_valid = r_word_valid;
    assign o_partial    = (r_cnt != '0);
    assign o_fourth     = w_fourth;

endmodule

// File: rtl/imem_loader.sv
// Instruction loader: clears imem, loads a byte-streamed program, then runs the CPU
// for a fixed cycle budget. load_req_i / rst_i restart the whole sequence.
module imem_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int RUN_CYCLES = 30
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          load_req_i,
    imem_loader_if.slave  bus,
    output logic          cpu_rst_n_o,
    output logic          cpu_start_o,
    output logic [ADDR_W:0] words_o,
    output logic          done_o,
    output logic          err_o
);

    localparam logic [ADDR_W:0]   FULL_WORDS = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W-1:0] LAST_ADDR  = '1;
    localparam logic [31:0]       RUN_LAST   = 32'(RUN_CYCLES - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [ADDR_W-1:0]  r_clr_addr;
    logic [ADDR_W:0]    r_words;
    logic [31:0]        r_cyc;
    logic               r_last_word;

    logic               w_restart;
    logic               w_hs;
    logic               w_full;
    logic               w_err_full;
    logic               w_err_last;
    logic               w_push;
    logic               w_pack_clr;
    logic               w_budget_hit;
    logic [WORD_W-1:0]  w_word;
    logic               w_word_valid;
    logic               w_partial;
    logic               w_fourth;

    assign w_restart    = rst_i | load_req_i;
    assign w_hs         = bus.s_valid_i & (r_state == ST_RECV);
    assign w_full       = (r_words == FULL_WORDS);
    assign w_err_full   = w_hs & w_full;
    // A last byte is legal only when it completes a word already in progress.
    assign w_err_last   = w_hs & ~w_full & bus.s_last_i & ~(w_partial & w_fourth);
    assign w_push       = w_hs & ~w_full & ~w_err_last & ~w_restart;
    assign w_pack_clr   = w_restart | w_err_full | w_err_last;
    assign w_budget_hit = (RUN_CYCLES != 0) && (r_cyc == RUN_LAST);

    byte_packer u_packer (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .i_clr        (w_pack_clr),
        .i_push       (w_push),
        .i_data       (bus.s_data_i),
        .o_word       (w_word),
        .o_word_valid (w_word_valid),
        .o_partial    (w_partial),
        .o_fourth     (w_fourth)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_CLEAR: if (r_clr_addr == LAST_ADDR) w_state_next = ST_RECV;
            ST_RECV: begin
                if (w_err_full || w_err_last) begin
                    w_state_next = ST_ERR;
                end else if (w_push && w_fourth) begin
                    w_state_next = ST_WRITE;
                end
            end
            ST_WRITE: w_state_next = r_last_word ? ST_RUN : ST_RECV;
            ST_RUN:   if (w_budget_hit) w_state_next = ST_HALT;
            ST_HALT:  w_state_next = ST_HALT;
            ST_ERR:   w_state_next = ST_ERR;
            default:  w_state_next = ST_CLEAR;
        endcase
        if (load_req_i) begin
            w_state_next = ST_CLEAR;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_restart) begin
            r_state     <= ST_CLEAR;
            r_clr_addr  <= '0;
            r_words     <= '0;
            r_cyc       <= '0;
            r_last_word <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (r_state == ST_CLEAR) begin
                r_clr_addr <= r_clr_addr + 1'b1;
            end
            if (r_state == ST_WRITE) begin
                r_words <= r_words + 1'b1;
            end
            if (r_state == ST_RUN) begin
                r_cyc <= r_cyc + 32'd1;
            end
            if (w_push && w_fourth) begin
                r_last_word <= bus.s_last_i;
            end
        end
    end

    always_comb begin
        bus.s_ready_o    = 1'b0;
        bus.imem_we_o    = 1'b0;
        bus.imem_addr_o  = '0;
        bus.imem_wdata_o = '0;
        case (r_state)
            ST_CLEAR: begin
                bus.imem_we_o   = 1'b1;
                bus.imem_addr_o = r_clr_addr;
            end
            ST_RECV: bus.s_ready_o = 1'b1;
            ST_WRITE: begin
                bus.imem_we_o    = w_word_valid;
                bus.imem_addr_o  = r_words[ADDR_W-1:0];
                bus.imem_wdata_o = w_word;
            end
            default: ;
        endcase
    end

    assign cpu_rst_n_o = cpu_released(r_state);
    assign cpu_start_o = (r_state == ST_RUN);
    assign done_o      = (r_state == ST_HALT);
    assign err_o       = (r_state == ST_ERR);
    assign words_o     = r_words;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a byte-level program model predicts every memory
// write, and a per-cycle compare process checks clear sweeps and writes against it.
module tb_imem_loader;

    localparam int ADDR_W     = 8;
    localparam int RUN_CYCLES = 30;
    localparam int DEPTH      = 1 << ADDR_W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic            load_req;
    logic            cpu_rst_n;
    logic            cpu_start;
    logic [ADDR_W:0] words;
    logic            done;
    logic            err;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_loader #(.ADDR_W(ADDR_W), .RUN_CYCLES(RUN_CYCLES)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .load_req_i  (load_req),
        .bus         (bus),
        .cpu_rst_n_o (cpu_rst_n),
        .cpu_start_o (cpu_start),
        .words_o     (words),
        .done_o      (done),
        .err_o       (err)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Program-level model: bytes in, expected (address, word) writes out.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    wr_t        exp_wr[$];
    logic [31:0] log_data[$];
    int         log_addr[$];
    logic [7:0] m_part[$];
    int         m_words;
    bit         m_err;

    function automatic void model_reset();
        exp_wr.delete();
        log_data.delete();
        log_addr.delete();
        m_part.delete();
        m_words = 0;
        m_err   = 1'b0;
    endfunction

    function automatic void model_accept(input logic [7:0] d, input bit last);
        wr_t w;
        if (m_err) return;
        if (m_words == DEPTH) begin
            m_err = 1'b1;
            m_part.delete();
            return;
        end
        m_part.push_back(d);
        if (m_part.size() == 4) begin
            w.addr = m_words[ADDR_W-1:0];
            w.data = {m_part[0], m_part[1], m_part[2], m_part[3]};
            exp_wr.push_back(w);
            m_words++;
            m_part.delete();
        end else if (last) begin
            m_err = 1'b1;
            m_part.delete();
        end
    endfunction

    function automatic logic [31:0] log_word(input int i);
        if (log_data.size() > i) return log_data[i];
        return 'x;
    endfunction

    // Per-cycle compare: clear sweep after every restart, then model-predicted writes.
    int  clr_n = -1;
    bit  armed = 1'b0;
    wr_t cmp_w;

    always @(negedge clk) begin
        if (armed) begin
            if (clr_n >= 0 && clr_n < DEPTH) begin
                check("clear_we",      bus.imem_we_o, 1);
                check("clear_addr",    bus.imem_addr_o, clr_n);
                check("clear_data",    bus.imem_wdata_o, 0);
                check("clear_ready",   bus.s_ready_o, 0);
                check("clear_cpu_rst", cpu_rst_n, 0);
                check("clear_start",   cpu_start, 0);
                check("clear_words",   words, 0);
                check("clear_flags",   {done, err}, 0);
            end else begin
                if (clr_n == DEPTH) check("ready_after_clear", bus.s_ready_o, 1);
                if (bus.imem_we_o) begin
                    if (exp_wr.size() == 0) begin
                        check("write_without_expectation", bus.imem_we_o, 0);
                    end else begin
                        cmp_w = exp_wr.pop_front();
                        check("write_addr", bus.imem_addr_o, cmp_w.addr);
                        check("write_data", bus.imem_wdata_o, cmp_w.data);
                        log_addr.push_back(int'(bus.imem_addr_o));
                        log_data.push_back(bus.imem_wdata_o);
                    end
                end
                check("ready_and_write_exclusive", bus.s_ready_o & bus.imem_we_o, 0);
                check("start_needs_release", cpu_start & ~cpu_rst_n, 0);
            end
        end
        if (rst || load_req) begin
            armed = 1'b1;
            clr_n = 0;
        end else if (clr_n >= 0) begin
            clr_n = (clr_n == DEPTH) ? -1 : clr_n + 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic restart(input bit use_rst);
        if (use_rst) rst = 1'b1; else load_req = 1'b1;
        model_reset();
        step();
        rst      = 1'b0;
        load_req = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input bit last);
        bit ok = 1'b0;
        bit rdy;
        bus.s_valid_i = 1'b1;
        bus.s_data_i  = d;
        bus.s_last_i  = last;
        for (int n = 0; n < 1000 && !ok; n++) begin
            @(negedge clk);
            rdy = bus.s_ready_o;
            step();
            ok = rdy;
        end
        bus.s_valid_i = 1'b0;
        bus.s_last_i  = 1'b0;
        check("byte_accepted", ok, 1);
        if (ok) model_accept(d, last);
    endtask

    logic [7:0] prog [8] = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20};
    logic [7:0] part [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    logic [7:0] tail [4] = '{8'hCA, 8'hFE, 8'hBA, 8'hBE};

    task automatic load_prog();
        for (int i = 0; i < 8; i++) send_byte(prog[i], i == 7);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi;
        rst = 1'b0;
        load_req = 1'b0;
        bus.s_valid_i = 1'b0;
        bus.s_data_i  = 8'h00;
        bus.s_last_i  = 1'b0;
        model_reset();
        repeat (2) step();

        // Reset values
        restart(1'b1);
        @(negedge clk);
        check("rst_we", bus.imem_we_o, 1);
        check("rst_addr", bus.imem_addr_o, 0);
        check("rst_data", bus.imem_wdata_o, 0);
        check("rst_ready_cpu", {bus.s_ready_o, cpu_rst_n, cpu_start}, 0);
        check("rst_words_flags", {words, done, err}, 0);
        step();

        // Program load, run, halt
        load_prog();
        @(negedge clk);
        check("start_low_in_write", cpu_start, 0);
        @(negedge clk);
        check("run_start", cpu_start, 1);
        check("run_cpu_rst_n", cpu_rst_n, 1);
        check("run_words", words, 2);
        check("prog_word0", log_word(0), 32'h20080005);
        check("prog_word1", log_word(1), 32'h01095020);
        hi = 1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (!cpu_start) break;
            hi++;
        end
        check("run_length", hi, 30);
        check("halt_done", done, 1);
        check("halt_cpu_rst_n", cpu_rst_n, 1);
        check("halt_start", cpu_start, 0);
        repeat (3) @(negedge clk);
        check("halt_hold", {done, cpu_rst_n, cpu_start, err}, 4'b1100);

        // Restart from HALT, reload, then restart in RUN
        step();
        restart(1'b0);
        @(negedge clk);
        check("halt_restart_flags", {words, done, err}, 0);
        step();
        load_prog();
        repeat (5) @(negedge clk);
        check("second_run_start", cpu_start, 1);
        step();
        restart(1'b0);
        @(negedge clk);
        check("run_restart_we", bus.imem_we_o, 1);
        check("run_restart_words", words, 0);
        check("run_restart_cpu", {cpu_rst_n, cpu_start, done, err}, 0);
        step();

        // Partial final word
        for (int i = 0; i < 6; i++) send_byte(part[i], i == 5);
        @(negedge clk);
        check("partial_err", err, 1);
        check("partial_cpu_rst_n", cpu_rst_n, 0);
        check("partial_ready", bus.s_ready_o, 0);
        check("partial_words", words, 1);
        check("partial_word0", log_word(0), 32'h11223344);
        repeat (3) @(negedge clk);
        check("partial_log_size", log_data.size(), 1);
        step();

        // Restart in ERR
        restart(1'b0);
        @(negedge clk);
        check("err_restart_flags", {words, done, err, cpu_rst_n}, 0);
        step();

        // Stray s_last without handshake, then restart mid-word with a colliding byte
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        bus.s_last_i = 1'b1;
        step();
        bus.s_last_i = 1'b0;
        @(negedge clk);
        check("stray_last_err", err, 0);
        check("stray_last_ready", bus.s_ready_o, 1);
        step();
        bus.s_valid_i = 1'b1;
        bus.s_data_i  = 8'h77;
        load_req      = 1'b1;
        model_reset();
        step();
        bus.s_valid_i = 1'b0;
        load_req      = 1'b0;
        @(negedge clk);
        check("midword_restart_we", bus.imem_we_o, 1);
        check("midword_restart_words", words, 0);
        step();
        for (int i = 0; i < 4; i++) send_byte(tail[i], i == 3);
        @(negedge clk);
        @(negedge clk);
        check("midword_run", cpu_start, 1);
        check("midword_words", words, 1);
        check("midword_word0", log_word(0), 32'hCAFEBABE);
        step();

        // Overflow
        restart(1'b0);
        for (int i = 0; i < 4 * DEPTH; i++) send_byte(8'(i * 7 + 3), 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("full_words", words, DEPTH);
        check("full_no_err", err, 0);
        step();
        send_byte(8'h5A, 1'b0);
        @(negedge clk);
        check("overflow_err", err, 1);
        check("overflow_words", words, DEPTH);
        check("overflow_cpu_rst_n", cpu_rst_n, 0);
        check("overflow_log_size", log_data.size(), DEPTH);
        check("overflow_word0", log_word(0), 32'h030A1118);
        check("overflow_word255", log_word(255), 32'hE7EEF5FC);
        check("overflow_pending", exp_wr.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Hardware instruction loader for the single-cycle CPU. It clears instruction memory, receives a program as a byte stream, packs the bytes into 32-bit words, and writes them into instruction memory. It then releases the CPU from reset, asserts start, and halts the CPU after a fixed cycle budget. It sits between a host byte link (UART or debug bridge) and the CPU's `Instruction_Memory` write port, `rst_i` and `start_i`.

## Interface
Parameters:
- `ADDR_W`, 8: instruction memory word-address width (256 words).
- `RUN_CYCLES`, 30: number of CPU cycles allowed before halt. 0 means unlimited.

Ports:
- `clk_i`  in  1  system clock, shared with the CPU.
- `rst_i`  in  1  reset; synchronous and active-high.
- `s_valid_i`  in  1  byte stream valid.
- `s_data_i`  in  8  byte stream data.
- `s_last_i`  in  1  marks the final byte of the program; qualified by the handshake.
- `s_ready_o`  out  1  byte stream ready.
- `load_req_i`  in  1  single-cycle pulse that restarts the load sequence.
- `imem_we_o`  out  1  instruction memory write enable.
- `imem_addr_o`  out  ADDR_W  instruction memory word address.
- `imem_wdata_o`  out  32  instruction memory write data.
- `cpu_rst_n_o`  out  1  CPU reset, active-low; drives CPU `rst_i`.
- `cpu_start_o`  out  1  drives CPU `start_i`.
- `words_o`  out  ADDR_W+1  number of words loaded.
- `done_o`  out  1  high when the CPU has halted after its budget.
- `err_o`  out  1  high when a load error is latched.

## Operation
States:
- CLEAR: write 0 to address k on cycle k, for k = 0..2^ADDR_W−1. `s_ready_o`=0. After the last address, go to RECV.
- RECV: `s_ready_o`=1. Accept a byte on `s_valid_i & s_ready_o`. Bytes are packed big-endian: the first byte goes to [31:24], the fourth to [7:0]. The 4th accepted byte moves the FSM to WRITE.
- WRITE: a single cycle with `imem_we_o`=1, `imem_addr_o`=word index, `imem_wdata_o`=packed word, `s_ready_o`=0.
  - Then increment the word index and `words_o`.
  - If the 4th byte carried `s_last_i`, go to RUN; otherwise return to RECV.
- RUN: `cpu_rst_n_o`=1, `cpu_start_o`=1, and the cycle counter increments every cycle. When the count reaches `RUN_CYCLES` (nonzero), go to HALT.
- HALT: `cpu_start_o`=0, `cpu_rst_n_o` stays 1 so CPU state is preserved for inspection, `done_o`=1.
- ERR: `err_o`=1, `cpu_rst_n_o`=0, `s_ready_o`=0.

Error conditions (both discard any partial word):
- `s_last_i` accepted with a byte count not a multiple of 4 → ERR.
- A byte accepted in RECV while the word index equals 2^ADDR_W (memory full) → ERR.

Restart:
- `load_req_i` in any state → CLEAR next cycle.
- The restart resets the byte count, word index, `words_o`, cycle counter, `err_o` and `done_o`.

Reset and CPU control:
- `rst_i` behaves like `load_req_i` and takes priority over every other event.
- `cpu_rst_n_o`=0 in CLEAR, RECV, WRITE and ERR.

## Timing
- Reset values on the cycle after `rst_i`:
  - State CLEAR, `imem_we_o`=1, `imem_addr_o`=0, `imem_wdata_o`=0.
  - `s_ready_o`=0, `cpu_rst_n_o`=0, `cpu_start_o`=0.
  - `words_o`=0, `done_o`=0, `err_o`=0.
- CLEAR lasts exactly 2^ADDR_W cycles.
- A memory write occurs 1 cycle after the 4th byte handshake. Peak stream throughput is 4 bytes per 5 cycles.
- `cpu_start_o` rises the cycle after the final WRITE cycle.
- HALT is entered exactly `RUN_CYCLES` cycles after RUN is entered.
- `load_req_i` together with a byte handshake in the same cycle: the byte is dropped and the restart wins.
- `s_last_i` is ignored unless the byte handshake occurs.

## Structure
- Shared package `loader_pkg`:
  - State enum (CLEAR, RECV, WRITE, RUN, HALT, ERR).
  - Constant `WORD_BYTES`=4.
- One natural sub-module, `byte_packer`: a 2-bit byte counter plus a 32-bit shift register, with `word_valid` and `partial` outputs.
- The FSM and counters stay in `imem_loader`.

## Test plan
- Reset, then check memory clear: 256 cycles of `imem_we_o` with data 0 at addresses 0..255, then `s_ready_o`=1.
- Program load: stream 8 bytes 20 08 00 05 01 09 50 20 with `s_last_i` on the 8th byte.
  - Expect writes at address 0 = 0x20080005 and address 1 = 0x01095020.
  - Expect `words_o`=2, `cpu_rst_n_o`=1, `cpu_start_o`=1.
- Partial word: 6 bytes with `s_last_i` on the 6th → `err_o`=1, no write for the partial word, `cpu_rst_n_o`=0.
- Overflow: 1024 bytes with no `s_last_i`, then 1 more byte → `err_o`=1, `words_o`=256.
- Cycle budget: with `RUN_CYCLES`=30, `cpu_start_o` falls exactly 30 cycles after it rises, `done_o`=1, `cpu_rst_n_o` stays 1.
- Restart: pulse `load_req_i` in RUN, in ERR, and during a half-received word.
  - Each time expect CLEAR next cycle, `words_o`=0, flags cleared, `cpu_rst_n_o`=0.
